// File: rtl/phase_accumulator_tdm.sv
// phase_accumulator_tdm
//
// Time-multiplexed phase accumulator. One adder serves all voices. A sample tick starts a
// sweep, and the sweep processes one voice per cycle. Each voice increment comes from a
// table that can be rewritten at any time. Each result streams out as
// {phase, voice index, carry} for the waveform lookup stage that follows.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   sample_tick_in  one-cycle pulse that starts a sweep over all voices
//   gate_in         per-voice note-on level, captured when a sweep starts
//   inc_wr_en_in    increment table write strobe
//   inc_wr_addr_in  voice whose increment is written; out-of-range addresses are ignored
//   inc_wr_data_in  new increment value
//   phase_out       updated phase of voice_out
//   voice_out       voice index of the current result
//   phase_valid_out result strobe, high for NUM_VOICES consecutive cycles per sweep
//   wrap_out        carry out of the phase add for this result
//   busy_out        sweep in progress
//   overrun_out     one-cycle pulse after a tick that arrived during a sweep was dropped

module phase_accumulator_tdm #(
    parameter int unsigned NUM_VOICES  = 24,
    parameter int unsigned PHASE_WIDTH = 32,
    localparam int unsigned VW = $clog2(NUM_VOICES)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   sample_tick_in,
    input  logic [NUM_VOICES-1:0]  gate_in,
    input  logic                   inc_wr_en_in,
    input  logic [VW-1:0]          inc_wr_addr_in,
    input  logic [PHASE_WIDTH-1:0] inc_wr_data_in,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [VW-1:0]          voice_out,
    output logic                   phase_valid_out,
    output logic                   wrap_out,
    output logic                   busy_out,
    output logic                   overrun_out
);

    typedef enum logic {StIdle = 1'b0, StSweep = 1'b1} state_e;

    localparam logic [VW-1:0] LastVoice = VW'(NUM_VOICES - 1);

    state_e                 state_q, state_d;
    logic [VW-1:0]          v_q, v_d;
    logic                   last_voice;
    logic                   tick_take;
    logic                   tick_drop;
    logic                   wr_hit;

    logic [NUM_VOICES-1:0]  gate_snap_q;
    logic [NUM_VOICES-1:0]  prev_gate_q;
    logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] inc_q   [NUM_VOICES];

    logic                   accumulate;
    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH-1:0] new_phase;
    logic                   new_wrap;

    assign last_voice = (v_q == LastVoice);
    assign busy_out   = (state_q == StSweep);

    // Extra bit so the range compare also works when NUM_VOICES is a power of two.
    assign wr_hit = inc_wr_en_in && ({1'b0, inc_wr_addr_in} < (VW + 1)'(NUM_VOICES));

    // Sweep control.
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        tick_take = 1'b0;
        tick_drop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_tick_in) begin
                    tick_take = 1'b1;
                    state_d   = StSweep;
                    v_d       = '0;
                end
            end
            StSweep: begin
                // A tick arriving in any sweep cycle, including the last one, is dropped.
                tick_drop = sample_tick_in;
                if (last_voice) begin
                    state_d = StIdle;
                    v_d     = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                v_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
        end
    end

    // Shared adder. A voice accumulates only if it was gated in both this sweep and the
    // previous one. A fresh note start, or a released voice, restarts from zero.
    always_comb begin
        accumulate = gate_snap_q[v_q] & prev_gate_q[v_q];
        sum        = {1'b0, phase_q[v_q]} + {1'b0, inc_q[v_q]};
        new_phase  = accumulate ? sum[PHASE_WIDTH-1:0] : '0;
        new_wrap   = accumulate & sum[PHASE_WIDTH];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
            gate_snap_q     <= '0;
            prev_gate_q     <= '0;
            phase_out       <= '0;
            voice_out       <= '0;
            wrap_out        <= 1'b0;
            phase_valid_out <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            phase_valid_out <= (state_q == StSweep);
            overrun_out     <= tick_drop;

            if (tick_take) begin
                gate_snap_q <= gate_in;
            end

            // Result outputs hold their last values between sweeps.
            if (state_q == StSweep) begin
                phase_q[v_q] <= new_phase;
                phase_out    <= new_phase;
                voice_out    <= v_q;
                wrap_out     <= new_wrap;
                if (last_voice) begin
                    prev_gate_q <= gate_snap_q;
                end
            end

            // This cycle's add already read the old entry, so a colliding write takes
            // effect from the next sweep.
            if (wr_hit) begin
                inc_q[inc_wr_addr_in] <= inc_wr_data_in;
            end
        end
    end

endmodule

// File: tb/tb_phase_accumulator_tdm.sv
// Testbench for phase_accumulator_tdm. The main instance has NUM_VOICES=4 and
// PHASE_WIDTH=8. A second instance has 5 voices, so the address field is wide enough to
// hold out-of-range addresses.

module tb_phase_accumulator_tdm;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] gate;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] phase;
    logic [1:0] voice;
    logic       valid;
    logic       wrap;
    logic       busy;
    logic       overrun;

    logic       tick2;
    logic [4:0] gate2;
    logic       wr_en2;
    logic [2:0] wr_addr2;
    logic [7:0] wr_data2;
    logic [7:0] phase2;
    logic [2:0] voice2;
    logic       valid2;
    logic       wrap2;
    logic       busy2;
    logic       overrun2;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] mon_voice [$];
    logic [7:0] mon_phase [$];
    logic       mon_wrap  [$];
    logic [2:0] mon2_voice [$];
    logic [7:0] mon2_phase [$];

    always #5 clk = ~clk;

    phase_accumulator_tdm #(
        .NUM_VOICES (4),
        .PHASE_WIDTH(8)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .sample_tick_in (tick),
        .gate_in        (gate),
        .inc_wr_en_in   (wr_en),
        .inc_wr_addr_in (wr_addr),
        .inc_wr_data_in (wr_data),
        .phase_out      (phase),
        .voice_out      (voice),
        .phase_valid_out(valid),
        .wrap_out       (wrap),
        .busy_out       (busy),
        .overrun_out    (overrun)
    );

    phase_accumulator_tdm #(
        .NUM_VOICES (5),
        .PHASE_WIDTH(8)
    ) dut2 (
        .clk_in         (clk),
        .rst_in         (rst),
        .sample_tick_in (tick2),
        .gate_in        (gate2),
        .inc_wr_en_in   (wr_en2),
        .inc_wr_addr_in (wr_addr2),
        .inc_wr_data_in (wr_data2),
        .phase_out      (phase2),
        .voice_out      (voice2),
        .phase_valid_out(valid2),
        .wrap_out       (wrap2),
        .busy_out       (busy2),
        .overrun_out    (overrun2)
    );

    // Log every result, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            mon_voice.push_back(voice);
            mon_phase.push_back(phase);
            mon_wrap.push_back(wrap);
        end
        if (valid2) begin
            mon2_voice.push_back(voice2);
            mon2_phase.push_back(phase2);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_voice.delete();
        mon_phase.delete();
        mon_wrap.delete();
    endtask

    task automatic write_inc(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic write_inc2(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en2   = 1'b1;
        wr_addr2 = a;
        wr_data2 = d;
        @(negedge clk);
        wr_en2   = 1'b0;
    endtask

    // exp_ph packs voice i's phase in bits [8*i +: 8]; exp_wrap bit i is voice i's carry.
    task automatic check_results(input string tag, input logic [31:0] exp_ph,
                                 input logic [3:0] exp_wrap);
        int n;
        n = mon_phase.size();
        check_eq({tag, "_count"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_v%0d_idx", tag, i), (i < n) ? mon_voice[i] : 2'bxx, i);
            check_eq($sformatf("%s_v%0d_phase", tag, i), (i < n) ? mon_phase[i] : 8'hxx,
                     exp_ph[8*i +: 8]);
            check_eq($sformatf("%s_v%0d_wrap", tag, i), (i < n) ? mon_wrap[i] : 1'bx,
                     exp_wrap[i]);
        end
    endtask

    // One tick followed by a full sweep. gate_in is inverted during the sweep and must
    // have no effect. An optional increment write lands on the cycle voice 1 is processed.
    task automatic run_sweep(input string tag, input logic [31:0] exp_ph,
                             input logic [3:0] exp_wrap, input bit do_wr,
                             input logic [1:0] a, input logic [7:0] d);
        logic [3:0] gate_save;
        @(negedge clk);
        clear_mon();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq({tag, "_busy_start"}, busy, 1);
        gate_save = gate;
        gate      = ~gate;
        @(negedge clk);
        if (do_wr) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = d;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        gate = gate_save;
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_overrun"}, overrun, 0);
        check_results(tag, exp_ph, exp_wrap);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] exp2_s1;
        logic [39:0] exp2_s2;
        int          n2;

        rst      = 1'b1;
        tick     = 1'b0;
        gate     = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tick2    = 1'b0;
        gate2    = '0;
        wr_en2   = 1'b0;
        wr_addr2 = '0;
        wr_data2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_phase", phase, 0);
        check_eq("rst_voice", voice, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);

        // Reset asserted mid-sweep.
        gate = 4'hF;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_valid_before", valid, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_voice", voice, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_phase", phase, 0);
        @(negedge clk);
        rst  = 1'b0;
        gate = '0;
        clear_mon();
        repeat (10) @(negedge clk);
        check_eq("idle_no_valids", mon_phase.size(), 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_voice", voice, 0);
        check_eq("idle_overrun", overrun, 0);

        // Basic accumulation on voice 2.
        write_inc(2'd2, 8'h30);
        gate = 4'b0100;
        run_sweep("acc1", 32'h0000_0000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("acc2", 32'h0030_0000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("acc3", 32'h0060_0000, 4'b0000, 0, 2'd0, 8'h00);

        // Wrap on voice 0 while voice 2 keeps running.
        write_inc(2'd0, 8'hF0);
        gate = 4'b0101;
        run_sweep("wrap1", 32'h0090_0000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("wrap2", 32'h00C0_00F0, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("wrap3", 32'h00F0_00E0, 4'b0001, 0, 2'd0, 8'h00);
        run_sweep("wrap4", 32'h0020_00D0, 4'b0101, 0, 2'd0, 8'h00);

        // Release voice 2 for one sweep, then retrigger it.
        gate = 4'b0001;
        run_sweep("rel", 32'h0000_00C0, 4'b0001, 0, 2'd0, 8'h00);
        gate = 4'b0101;
        run_sweep("retrig", 32'h0000_00B0, 4'b0001, 0, 2'd0, 8'h00);
        run_sweep("resume", 32'h0030_00A0, 4'b0001, 0, 2'd0, 8'h00);

        // Second tick two cycles after the first is dropped.
        @(negedge clk);
        clear_mon();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("ovr_quiet", overrun, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("ovr_pulse", overrun, 1);
        @(negedge clk);
        check_eq("ovr_pulse_end", overrun, 0);
        repeat (10) @(negedge clk);
        check_eq("ovr_busy_end", busy, 0);
        check_results("ovr", 32'h0060_0090, 4'b0001);

        // Increment write colliding with voice 1's processing cycle.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        write_inc(2'd1, 8'h20);
        gate = 4'b0010;
        run_sweep("col_a", 32'h0000_0000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("col_b", 32'h0000_2000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("col_c", 32'h0000_4000, 4'b0000, 0, 2'd0, 8'h00);
        run_sweep("col_d", 32'h0000_6000, 4'b0000, 1, 2'd1, 8'h10);
        run_sweep("col_e", 32'h0000_7000, 4'b0000, 0, 2'd0, 8'h00);

        // Out-of-range increment addresses on the 5-voice instance.
        gate2 = 5'h1F;
        write_inc2(3'd1, 8'h11);
        write_inc2(3'd4, 8'h02);
        write_inc2(3'd5, 8'hFF);
        write_inc2(3'd6, 8'hFF);
        write_inc2(3'd7, 8'hFF);
        mon2_voice.delete();
        mon2_phase.delete();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            tick2 = 1'b1;
            @(negedge clk);
            tick2 = 1'b0;
            repeat (8) @(negedge clk);
        end
        // Voice 4 is the most significant byte.
        exp2_s1 = 40'h02_00_00_11_00;
        exp2_s2 = 40'h04_00_00_22_00;
        n2 = mon2_phase.size();
        check_eq("ign_count", n2, 15);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("ign_s1_v%0d_idx", i), (5 + i < n2) ? mon2_voice[5 + i] : 3'bxxx,
                     i);
            check_eq($sformatf("ign_s1_v%0d_phase", i),
                     (5 + i < n2) ? mon2_phase[5 + i] : 8'hxx, exp2_s1[8*i +: 8]);
            check_eq($sformatf("ign_s2_v%0d_phase", i),
                     (10 + i < n2) ? mon2_phase[10 + i] : 8'hxx, exp2_s2[8*i +: 8]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
